dt_skeleton: RTL and testbench

- Downstream stage of the distance-transform block.
- Once the distance map in the 128x128 result RAM is final, scans it in raster order and marks each nonzero pixel that is a 4-neighbour local maximum (a medial-axis/skeleton pixel).
- Packs skeleton bits into 16-bit words in the same layout as the binary source ROM (1024 x 16) and reports the global maximum distance and its address.
- Started by the distance-transform `done` pulse/level.

---
 rtl/dt_pkg.sv | 33 +++
 rtl/dt_skel_packer.sv | 51 +++++
 rtl/dt_skeleton.sv | 159 +++++++++++++++
 tb/tb_dt_skeleton.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared types and constants for the distance-transform skeleton stage:
// image geometry, address layouts, scan states and neighbour offsets.
package dt_pkg;

  localparam int IMG_W  = 128;
  localparam int LOG_W  = 7;
  localparam int PIX_W  = 8;
  localparam int WORD_W = 16;

  typedef logic [2*LOG_W-1:0] pix_addr_t;   // {row, col}
  typedef logic [2*LOG_W-5:0] word_addr_t;  // {row, col[6:4]}

  typedef enum logic [2:0] {
    IDLE,
    RD_C,
    RD_N,
    RD_S,
    RD_E,
    EVAL,
    DONE
  } skel_state_t;

  // Row/column steps from the centre pixel to the fetched neighbours
  localparam int NB_N_DROW = -1;
  localparam int NB_S_DROW = 1;
  localparam int NB_E_DCOL = 1;

  function automatic pix_addr_t pix_addr(input logic [LOG_W-1:0] row,
                                         input logic [LOG_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/dt_skel_packer.sv
// MSB-first 16-bit shift packer: one skeleton bit per shift, and on flush
// emits the completed word with its address as a one-cycle registered strobe.
module dt_skel_packer
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_shift_en,
  input  logic              i_bit,
  input  logic              i_flush,
  input  logic [9:0]        i_addr,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word,
  output logic [9:0]        o_addr
);

  logic [WORD_W-1:0] r_shift;
  logic [WORD_W-1:0] r_word;
  logic [9:0]        r_addr;
  logic              r_valid;
  logic [WORD_W-1:0] w_shift_next;

  assign w_shift_next = {r_shift[WORD_W-2:0], i_bit};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_word  <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_shift_en) begin
        // The flush bit is the 16th of the word, so it goes straight to the output
        if (i_flush) begin
          r_word  <= w_shift_next;
          r_addr  <= i_addr;
          r_valid <= 1'b1;
          r_shift <= '0;
        end else begin
          r_shift <= w_shift_next;
        end
      end
    end
  end

  assign o_word_valid = r_valid;
  assign o_word       = r_word;
  assign o_addr       = r_addr;

endmodule

// File: rtl/dt_skeleton.sv
// Raster scan of the final distance map: marks 4-neighbour local maxima,
// packs them into 16-bit skeleton words and tracks the global maximum.
module dt_skeleton
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              res_rd,
  output logic [13:0]       res_addr,
  input  logic [PIX_W-1:0]  res_di,
  output logic              skel_wr,
  output logic [9:0]        skel_addr,
  output logic [WORD_W-1:0] skel_do,
  output logic [PIX_W-1:0]  max_val,
  output logic [13:0]       max_addr
);

  localparam logic [LOG_W-1:0] LAST_IDX = LOG_W'(IMG_W - 1);
  localparam logic [LOG_W-1:0] STEP_N   = LOG_W'(NB_N_DROW);
  localparam logic [LOG_W-1:0] STEP_S   = LOG_W'(NB_S_DROW);
  localparam logic [LOG_W-1:0] STEP_E   = LOG_W'(NB_E_DCOL);

  skel_state_t      r_state;
  logic [LOG_W-1:0] r_row;
  logic [LOG_W-1:0] r_col;
  logic [PIX_W-1:0] r_w, r_c, r_e, r_n, r_s;
  logic [PIX_W-1:0] r_max;
  pix_addr_t        r_max_addr;
  logic             r_done;

  logic             w_rd;
  pix_addr_t        w_addr;
  logic [PIX_W-1:0] w_rd_data;
  logic             w_bit;
  logic             w_last_col;
  logic             w_last_row;

  // Out-of-image neighbours are never fetched; they simply read as zero
  always_comb begin
    w_rd   = 1'b0;
    w_addr = '0;
    case (r_state)
      RD_C: begin
        w_rd   = 1'b1;
        w_addr = pix_addr(r_row, '0);
      end
      RD_N: if (r_row != '0) begin
        w_rd   = 1'b1;
        w_addr = pix_addr(r_row + STEP_N, r_col);
      end
      RD_S: if (r_row != LAST_IDX) begin
        w_rd   = 1'b1;
        w_addr = pix_addr(r_row + STEP_S, r_col);
      end
      RD_E: if (r_col != LAST_IDX) begin
        w_rd   = 1'b1;
        w_addr = pix_addr(r_row, r_col + STEP_E);
      end
      default: ;
    endcase
  end

  assign w_rd_data  = w_rd ? res_di : '0;
  assign w_last_col = (r_col == LAST_IDX);
  assign w_last_row = (r_row == LAST_IDX);
  assign w_bit      = (r_c != '0) && (r_c >= r_n) && (r_c >= r_s) &&
                      (r_c >= r_w) && (r_c >= r_e);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_w        <= '0;
      r_c        <= '0;
      r_e        <= '0;
      r_n        <= '0;
      r_s        <= '0;
      r_max      <= '0;
      r_max_addr <= '0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) begin
          r_state    <= RD_C;
          r_row      <= '0;
          r_col      <= '0;
          r_w        <= '0;
          r_c        <= '0;
          r_e        <= '0;
          r_n        <= '0;
          r_s        <= '0;
          r_max      <= '0;
          r_max_addr <= '0;
          r_done     <= 1'b0;
        end
        RD_C: begin
          r_c     <= w_rd_data;
          r_w     <= '0;
          r_state <= RD_N;
        end
        RD_N: begin
          r_n     <= w_rd_data;
          r_state <= RD_S;
        end
        RD_S: begin
          r_s     <= w_rd_data;
          r_state <= RD_E;
        end
        RD_E: begin
          r_e     <= w_rd_data;
          r_state <= EVAL;
        end
        EVAL: begin
          // Strict compare keeps the raster-first address of the maximum
          if (r_c > r_max) begin
            r_max      <= r_c;
            r_max_addr <= pix_addr(r_row, r_col);
          end
          r_w <= r_c;
          r_c <= r_e;
          if (!w_last_col) begin
            r_col   <= r_col + 1'b1;
            r_state <= RD_N;
          end else if (!w_last_row) begin
            r_row   <= r_row + 1'b1;
            r_col   <= '0;
            r_state <= RD_C;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  dt_skel_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_shift_en   (r_state == EVAL),
    .i_bit        (w_bit),
    .i_flush      (&r_col[3:0]),
    .i_addr       ({r_row, r_col[LOG_W-1:4]}),
    .o_word_valid (skel_wr),
    .o_word       (skel_do),
    .o_addr       (skel_addr)
  );

  assign res_rd   = w_rd;
  assign res_addr = w_addr;
  assign done     = r_done;
  assign max_val  = r_max;
  assign max_addr = r_max_addr;

endmodule

// File: tb/tb_dt_skeleton.sv
// Bench for dt_skeleton: composite distance map, image-level reference model
// and a per-cycle write/read monitor, plus literal expectations.
module tb_dt_skeleton;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        done;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        skel_wr;
  logic [9:0]  skel_addr;
  logic [15:0] skel_do;
  logic [7:0]  max_val;
  logic [13:0] max_addr;

  dt_skeleton dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .res_rd    (res_rd),
    .res_addr  (res_addr),
    .res_di    (res_di),
    .skel_wr   (skel_wr),
    .skel_addr (skel_addr),
    .skel_do   (skel_do),
    .max_val   (max_val),
    .max_addr  (max_addr)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:16383];
  // Garbage on the bus when no read is requested; it must never be used
  assign res_di = res_rd ? mem[res_addr] : 8'hC3;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_word [0:1023];
  logic [15:0] got_word [0:1023];
  logic [7:0]  exp_max;
  logic [13:0] exp_max_addr;
  int          wr_count = 0;
  int          rd_count = 0;
  int          scan_gen = 0;
  int          seen_gen = 0;
  bit          scanning = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  function automatic int px(input int r, input int c);
    if (r < 0 || r > 127 || c < 0 || c > 127) return 0;
    return int'(mem[14'(r * 128 + c)]);
  endfunction

  // Reference: whole-image evaluation of the local-maximum rule and raster max
  task automatic build_model();
    int v;
    logic b;
    exp_max      = 8'd0;
    exp_max_addr = 14'd0;
    for (int i = 0; i < 1024; i++) exp_word[i] = 16'h0000;
    for (int r = 0; r < 128; r++) begin
      for (int c = 0; c < 128; c++) begin
        v = px(r, c);
        b = (v != 0) && (v >= px(r - 1, c)) && (v >= px(r + 1, c)) &&
            (v >= px(r, c - 1)) && (v >= px(r, c + 1));
        exp_word[r * 8 + c / 16][15 - (c % 16)] = b;
        if (v > int'(exp_max)) begin
          exp_max      = 8'(v);
          exp_max_addr = 14'(r * 128 + c);
        end
      end
    end
  endtask

  task automatic build_image();
    for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    for (int r = 0; r < 128; r++) begin
      mem[14'(r * 128 + 62)] = 8'd1;
      mem[14'(r * 128 + 63)] = 8'd2;
      mem[14'(r * 128 + 64)] = 8'd3;
      mem[14'(r * 128 + 65)] = 8'd2;
      mem[14'(r * 128 + 66)] = 8'd1;
    end
    mem[14'(10 * 128 + 20)]   = 8'd5;
    mem[14'(3 * 128 + 3)]     = 8'd9;
    mem[14'(100 * 128 + 100)] = 8'd9;
    mem[14'(0)]               = 8'd1;
    mem[14'(127 * 128 + 127)] = 8'd1;
    for (int r = 40; r <= 42; r++)
      for (int c = 30; c <= 32; c++) mem[14'(r * 128 + c)] = 8'd4;
    for (int r = 50; r <= 57; r++)
      for (int c = 0; c < 48; c++) mem[14'(r * 128 + c)] = 8'((r * 7 + c * 13) % 9);
  endtask

  // Per-cycle monitor: every write is checked in order against the model
  always @(negedge clk) begin
    if (scan_gen != seen_gen) begin
      seen_gen = scan_gen;
      wr_count = 0;
      rd_count = 0;
    end
    if (res_rd) rd_count++;
    if (skel_wr) begin
      if (!scanning) begin
        chk("stray_write", 32'(skel_wr), 32'd0);
      end else begin
        chk("wr_addr", 32'(skel_addr), 32'(wr_count % 1024));
        chk("wr_data", 32'(skel_do), 32'(exp_word[skel_addr]));
        got_word[skel_addr] = skel_do;
        if (wr_count == 1023) chk("last_wr_with_done", 32'(done), 32'd1);
        wr_count++;
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_res_rd"}, 32'(res_rd), 32'd0);
    chk({tag, "_res_addr"}, 32'(res_addr), 32'd0);
    chk({tag, "_skel_wr"}, 32'(skel_wr), 32'd0);
    chk({tag, "_skel_addr"}, 32'(skel_addr), 32'd0);
    chk({tag, "_skel_do"}, 32'(skel_do), 32'd0);
    chk({tag, "_max_val"}, 32'(max_val), 32'd0);
    chk({tag, "_max_addr"}, 32'(max_addr), 32'd0);
  endtask

  initial begin
    int cycles;
    reset = 1'b1;
    start = 1'b0;
    build_image();
    build_model();
    for (int i = 0; i < 1024; i++) got_word[i] = 16'hDEAD;

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    $display("reset state checked");

    // start together with reset: reset wins, block stays idle
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("start_with_reset_rd", 32'(res_rd), 32'd0);
    chk("start_with_reset_done", 32'(done), 32'd0);
    $display("start+reset collision checked");

    // scan aborted by reset partway through
    scan_gen++;
    scanning = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("first_read_rd", 32'(res_rd), 32'd1);
    chk("first_read_addr", 32'(res_addr), 32'd0);
    repeat (3000) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    scanning = 1'b0;
    chk_all_zero("abort");
    reset = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("abort_idle_rd", 32'(res_rd), 32'd0);
    $display("aborted scan after %0d writes", wr_count);

    // full scan on the same image, with a start pulse while busy
    scan_gen++;
    scanning = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cycles = 0;
    while (cycles < 70000) begin
      @(posedge clk);
      #1;
      cycles++;
      start = (cycles == 20000);
      if (done) break;
    end
    start = 1'b0;
    chk("scan_cycles", 32'(cycles), 32'd65664);
    @(negedge clk);
    #1;
    chk("write_count", 32'(wr_count), 32'd1024);
    chk("read_count", 32'(rd_count), 32'd48896);
    chk("max_val_model", 32'(max_val), 32'(exp_max));
    chk("max_addr_model", 32'(max_addr), 32'(exp_max_addr));
    chk("max_val_lit", 32'(max_val), 32'd9);
    chk("max_addr_lit", 32'(max_addr), 32'h0183);
    chk("word_single_px", 32'(got_word[10 * 8 + 1]), 32'h0800);
    chk("word_ridge_r0", 32'(got_word[0 * 8 + 4]), 32'h8000);
    chk("word_ridge_r64", 32'(got_word[64 * 8 + 4]), 32'h8000);
    chk("word_ridge_r127", 32'(got_word[127 * 8 + 4]), 32'h8000);
    chk("word_corner_first", 32'(got_word[0]), 32'h8000);
    chk("word_corner_last", 32'(got_word[1023]), 32'h0001);
    chk("word_peak_3_3", 32'(got_word[3 * 8 + 0]), 32'h1000);
    chk("word_peak_100_100", 32'(got_word[100 * 8 + 6]), 32'h0800);
    chk("word_beside_ridge", 32'(got_word[20 * 8 + 3]), 32'h0000);
    $display("full scan: %0d cycles, %0d writes, max %0d at %0h", cycles, wr_count, max_val, max_addr);

    // done holds, then a start from DONE restarts cleanly
    repeat (5) @(posedge clk);
    #1;
    chk("done_held", 32'(done), 32'd1);
    chk("no_write_in_done", 32'(skel_wr), 32'd0);
    scan_gen++;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_max", 32'(max_val), 32'd0);
    chk("restart_rd", 32'(res_rd), 32'd1);
    chk("restart_addr", 32'(res_addr), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    scanning = 1'b0;
    reset = 1'b0;
    chk("final_reset_rd", 32'(res_rd), 32'd0);
    $display("restart from DONE checked");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
